// File: rtl/rvfpm_xreg_wb.sv
// rvfpm_xreg_wb: follows X-register-writing FP ops through the rvfpm pipeline and queues their results for the integer core.
// Latency: result captured after PIPELINE_STAGES enabled cycles; it appears on wb_* one cycle later (no bypass).
// Backpressure: wb_valid/wb_ready pops the head; stall_req asks upstream to freeze before the FIFO could overflow.

// Generic synchronous FIFO with valid/ready on both sides.
// Latency: a written entry is readable the cycle after the write.
// Backpressure: in_rdy drops only when full and the head is not leaving this cycle.
module rvfpm_xreg_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic                       in_vld,
  input  logic [WIDTH-1:0]           in_dat,
  output logic                       in_rdy,
  output logic                       out_vld,
  output logic [WIDTH-1:0]           out_dat,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             wr_en;
  logic             rd_en;

  assign out_vld = (cnt_q != '0);
  assign rd_en   = out_vld && out_rdy;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign in_rdy  = (cnt_q != CW'(DEPTH)) || rd_en;
  assign wr_en   = in_vld && in_rdy;
  assign out_dat = mem[rd_ptr];
  assign count   = cnt_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are only observed through out_dat while out_vld is high.
  always_ff @(posedge ck) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_dat;
    end
  end

endmodule

module rvfpm_xreg_wb #(
  parameter int PIPELINE_STAGES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int XLEN            = 32
) (
  input  logic                            ck,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [31:0]                     instruction,
  input  logic [XLEN-1:0]                 data_toXReg,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [4:0]                      wb_rd,
  output logic [XLEN-1:0]                 wb_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            stall_req,
  output logic                            overflow_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(FIFO_DEPTH + PIPELINE_STAGES + 1);
  localparam int EW = 5 + XLEN;

  localparam logic [6:0] OP_FP      = 7'b1010011;
  localparam logic [6:0] F7_MV_CLS  = 7'b1110000;
  localparam logic [6:0] F7_CMP     = 7'b1010000;
  localparam logic [6:0] F7_CVT_W   = 7'b1100000;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } tag_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_ent_t;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rs2;
  logic       unused_rs1;
  logic       issue;

  tag_t       tag_q [PIPELINE_STAGES];
  tag_t       exit_tag;

  logic       push_vld;
  logic       push_rdy;
  wb_ent_t    push_dat;
  logic       head_vld;
  wb_ent_t    head_dat;
  logic [CW-1:0] cnt;

  logic [OW-1:0] occupancy;
  logic          ovf_q;

  assign opcode     = instruction[6:0];
  assign funct3     = instruction[14:12];
  assign rs2        = instruction[24:20];
  assign funct7     = instruction[31:25];
  assign unused_rs1 = ^instruction[19:15];

  // Decode: only FP ops whose result lands in the integer register file are tracked.
  always_comb begin
    issue = 1'b0;
    if (opcode == OP_FP) begin
      case (funct7)
        // FMV.X.W (funct3 000) and FCLASS.S (funct3 001)
        F7_MV_CLS: issue = (rs2 == 5'd0) && ((funct3 == 3'b000) || (funct3 == 3'b001));
        // FEQ.S / FLT.S / FLE.S
        F7_CMP:    issue = (funct3 == 3'b010) || (funct3 == 3'b001) || (funct3 == 3'b000);
        // FCVT.W.S / FCVT.WU.S
        F7_CVT_W:  issue = (rs2 == 5'd0) || (rs2 == 5'd1);
        default:   issue = 1'b0;
      endcase
    end
  end

  // Tag shift register, delay-matched to rvfpm; the whole pipe freezes with enable.
  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < PIPELINE_STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else if (enable) begin
      tag_q[0] <= '{v: issue, rd: instruction[11:7]};
      for (int i = 1; i < PIPELINE_STAGES; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign exit_tag = tag_q[PIPELINE_STAGES-1];

  // Capture happens only on an advancing cycle, so a frozen exit tag pushes exactly once.
  // Writes to x0 are architecturally discarded and never occupy a FIFO slot.
  assign push_vld = exit_tag.v && enable && (exit_tag.rd != 5'd0);
  assign push_dat = '{rd: exit_tag.rd, data: data_toXReg};

  rvfpm_xreg_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .ck      (ck),
    .rst     (rst),
    .in_vld  (push_vld),
    .in_dat  (push_dat),
    .in_rdy  (push_rdy),
    .out_vld (head_vld),
    .out_dat (head_dat),
    .out_rdy (wb_ready),
    .count   (cnt)
  );

  // Sticky loss flag: a result arrived while the FIFO was full and nothing was leaving.
  always_ff @(posedge ck) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (push_vld && !push_rdy) begin
      ovf_q <= 1'b1;
    end
  end

  // Worst-case demand: every queued entry plus every tag still in the pipe.
  always_comb begin
    occupancy = OW'(cnt);
    for (int i = 0; i < PIPELINE_STAGES; i++) begin
      occupancy = occupancy + OW'(tag_q[i].v);
    end
  end

  assign stall_req = (occupancy >= OW'(FIFO_DEPTH));

  // Head presentation; fields read zero whenever nothing is queued.
  always_comb begin
    wb_valid     = head_vld;
    wb_rd        = head_vld ? head_dat.rd : 5'd0;
    wb_data      = head_vld ? head_dat.data : '0;
    fifo_count   = cnt;
    overflow_err = ovf_q;
  end

endmodule

// File: tb/tb_rvfpm_xreg_wb.sv
// Bench for rvfpm_xreg_wb: directed vectors, queue-based reference model, per-cycle compare.
`timescale 1ns/1ps
module tb_rvfpm_xreg_wb;

  localparam int P = 4;
  localparam int D = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        ck;
  logic        rst;
  logic        enable;
  logic [31:0] instruction;
  logic [31:0] data_toXReg;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  fifo_count;
  logic        stall_req;
  logic        overflow_err;

  rvfpm_xreg_wb #(
    .PIPELINE_STAGES (P),
    .FIFO_DEPTH      (D),
    .XLEN            (32)
  ) dut (
    .ck           (ck),
    .rst          (rst),
    .enable       (enable),
    .instruction  (instruction),
    .data_toXReg  (data_toXReg),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .fifo_count   (fifo_count),
    .stall_req    (stall_req),
    .overflow_err (overflow_err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_on = 0;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [4:0] rd; int unsigned e; } pend_t;
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;

  pend_t       pend[$];   // issued, not yet at capture
  ent_t        mq[$];     // writeback queue
  int unsigned ecnt = 0;  // number of advancing edges seen
  bit          m_ovf = 0;

  function automatic bit m_tracked(input logic [31:0] ins);
    logic [6:0] f7;
    logic [4:0] r2;
    logic [2:0] f3;
    f7 = ins[31:25];
    r2 = ins[24:20];
    f3 = ins[14:12];
    if (ins[6:0] != 7'b1010011) return 1'b0;
    if (f7 == 7'b1110000 && r2 == 5'd0 && f3 == 3'b000) return 1'b1;
    if (f7 == 7'b1110000 && r2 == 5'd0 && f3 == 3'b001) return 1'b1;
    if (f7 == 7'b1010000 && (f3 == 3'b010 || f3 == 3'b001 || f3 == 3'b000)) return 1'b1;
    if (f7 == 7'b1100000 && (r2 == 5'd0 || r2 == 5'd1)) return 1'b1;
    return 1'b0;
  endfunction

  // An op issued on advancing edge k is captured on advancing edge k+P.
  always @(posedge ck) begin
    bit   pop;
    bit   push;
    ent_t e;
    if (rst) begin
      pend.delete();
      mq.delete();
      m_ovf = 0;
    end else begin
      pop  = (mq.size() > 0) && wb_ready;
      push = 0;
      e    = '0;
      if (enable) begin
        ecnt++;
        if (pend.size() > 0 && pend[0].e + P == ecnt) begin
          e.rd   = pend[0].rd;
          e.data = data_toXReg;
          push   = (e.rd != 5'd0);
          void'(pend.pop_front());
        end
        if (m_tracked(instruction)) pend.push_back('{rd: instruction[11:7], e: ecnt});
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < D) mq.push_back(e);
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge ck) begin
    if (chk_on) begin
      check("m_wb_valid", wb_valid, mq.size() > 0);
      check("m_wb_rd", wb_rd, (mq.size() > 0) ? mq[0].rd : 5'd0);
      check("m_wb_data", wb_data, (mq.size() > 0) ? mq[0].data : 32'd0);
      check("m_fifo_count", fifo_count, mq.size());
      check("m_stall_req", stall_req, (mq.size() + pend.size()) >= D);
      check("m_overflow_err", overflow_err, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] fp(input logic [6:0] f7, input logic [4:0] r2,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {f7, r2, 5'd3, f3, rd, 7'b1010011};
  endfunction

  task automatic step(input logic [31:0] ins, input logic [31:0] dat, input logic en, input logic rdy);
    instruction = ins;
    data_toXReg = dat;
    enable      = en;
    wb_ready    = rdy;
    @(posedge ck);
    #1;
  endtask

  task automatic idle(input int n, input logic en, input logic rdy);
    for (int k = 0; k < n; k++) step(NOP, 32'hC0DE_0000 + 32'(cyc), en, rdy);
  endtask

  task automatic issue(input logic [31:0] ins, input logic rdy);
    step(ins, 32'hC0DE_0000 + 32'(cyc), 1'b1, rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    instruction = NOP;
    data_toXReg = '0;
    enable = 1'b1;
    wb_ready = 1'b0;
    #1;
    idle(2, 1'b1, 1'b0);
    chk_on = 1;
    check("rst_valid", wb_valid, 0);
    check("rst_rd", wb_rd, 0);
    check("rst_data", wb_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_stall", stall_req, 0);
    check("rst_ovf", overflow_err, 0);
    rst = 1'b0;

    // T1: FMV.X.W rd=5, data in cycle 4, visible in cycle 5 only
    issue(fp(7'b1110000, 5'd0, 3'b000, 5'd5), 1'b1);
    idle(3, 1'b1, 1'b1);
    check("t1_early_valid", wb_valid, 0);
    step(NOP, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check("t1_valid", wb_valid, 1);
    check("t1_rd", wb_rd, 5);
    check("t1_data", wb_data, 32'hDEAD_BEEF);
    idle(1, 1'b1, 1'b1);
    check("t1_popped", wb_valid, 0);

    // T2: FEQ.S rd=0 never reaches the FIFO
    issue(fp(7'b1010000, 5'd2, 3'b010, 5'd0), 1'b0);
    idle(6, 1'b1, 1'b0);
    check("t2_count", fifo_count, 0);
    check("t2_valid", wb_valid, 0);

    // Untracked encodings: FADD.S, FMV.X.W rs2=1, FCVT rs2=2, compare funct3=011, funct7 1110000 funct3=010
    issue(fp(7'b0000000, 5'd2, 3'b000, 5'd3), 1'b0);
    issue(fp(7'b1110000, 5'd1, 3'b000, 5'd3), 1'b0);
    issue(fp(7'b1100000, 5'd2, 3'b000, 5'd3), 1'b0);
    issue(fp(7'b1010000, 5'd2, 3'b011, 5'd3), 1'b0);
    issue(fp(7'b1110000, 5'd0, 3'b010, 5'd3), 1'b0);
    issue({7'b1110000, 5'd0, 5'd3, 3'b000, 5'd3, 7'b1010111}, 1'b0);
    idle(6, 1'b1, 1'b0);
    check("untracked_count", fifo_count, 0);

    // FLT rd=8, FLE rd=9, FCVT.WU rd=6 back-to-back, drained as they arrive
    issue(fp(7'b1010000, 5'd2, 3'b001, 5'd8), 1'b1);
    issue(fp(7'b1010000, 5'd2, 3'b000, 5'd9), 1'b1);
    issue(fp(7'b1100000, 5'd1, 3'b000, 5'd6), 1'b1);
    idle(2, 1'b1, 1'b1);
    check("seq_rd8", wb_rd, 8);
    idle(1, 1'b1, 1'b1);
    check("seq_rd9", wb_rd, 9);
    idle(1, 1'b1, 1'b1);
    check("seq_rd6", wb_rd, 6);
    idle(1, 1'b1, 1'b1);
    check("seq_empty", wb_valid, 0);

    // T4: FCVT.W.S rd=7, frozen 3 cycles mid-flight -> visible in cycle 8
    issue(fp(7'b1100000, 5'd0, 3'b000, 5'd7), 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b0);
    idle(2, 1'b1, 1'b0);
    check("t4_not_yet", wb_valid, 0);
    step(NOP, 32'h7777_0007, 1'b1, 1'b0);
    check("t4_valid", wb_valid, 1);
    check("t4_rd", wb_rd, 7);
    check("t4_data", wb_data, 32'h7777_0007);
    idle(1, 1'b1, 1'b0);
    check("t4_single", fifo_count, 1);
    idle(1, 1'b1, 1'b1);
    check("t4_drained", fifo_count, 0);

    // T4b: freeze while the tag sits at the exit stage -> one push on the first advancing cycle
    issue(fp(7'b1110000, 5'd0, 3'b001, 5'd3), 1'b0);
    idle(3, 1'b1, 1'b0);
    step(NOP, 32'h1111_0001, 1'b0, 1'b0);
    step(NOP, 32'h1111_0002, 1'b0, 1'b0);
    step(NOP, 32'h1111_0003, 1'b0, 1'b0);
    check("t4b_frozen", wb_valid, 0);
    step(NOP, 32'h3333_0003, 1'b1, 1'b0);
    check("t4b_data", wb_data, 32'h3333_0003);
    idle(2, 1'b1, 1'b0);
    check("t4b_single", fifo_count, 1);
    idle(1, 1'b1, 1'b1);

    // T5: full FIFO, push and pop in the same cycle
    for (int r = 10; r <= 14; r++) issue(fp(7'b1110000, 5'd0, 3'b001, 5'(r)), 1'b0);
    idle(3, 1'b1, 1'b0);
    check("t5_full", fifo_count, 4);
    check("t5_head10", wb_rd, 10);
    idle(1, 1'b1, 1'b1);
    check("t5_count", fifo_count, 4);
    check("t5_no_ovf", overflow_err, 0);
    for (int r = 11; r <= 14; r++) begin
      check("t5_drain", wb_rd, 5'(r));
      idle(1, 1'b1, 1'b1);
    end
    check("t5_empty", wb_valid, 0);

    // T3: five FCLASS rd=1..5 with wb_ready low, stall_req ignored
    for (int r = 1; r <= 3; r++) issue(fp(7'b1110000, 5'd0, 3'b001, 5'(r)), 1'b0);
    check("t3_stall_lo", stall_req, 0);
    issue(fp(7'b1110000, 5'd0, 3'b001, 5'd4), 1'b0);
    check("t3_stall_hi", stall_req, 1);
    issue(fp(7'b1110000, 5'd0, 3'b001, 5'd5), 1'b0);
    idle(4, 1'b1, 1'b0);
    check("t3_ovf", overflow_err, 1);
    check("t3_count", fifo_count, 4);
    for (int r = 1; r <= 4; r++) begin
      check("t3_drain", wb_rd, 5'(r));
      idle(1, 1'b1, 1'b1);
    end
    check("t3_empty", wb_valid, 0);
    check("t3_ovf_sticky", overflow_err, 1);
    rst = 1'b1;
    idle(1, 1'b1, 1'b0);
    rst = 1'b0;
    check("t3_ovf_cleared", overflow_err, 0);

    // T6: reset with 2 tags in flight and 3 queued
    for (int r = 20; r <= 22; r++) issue(fp(7'b1010000, 5'd2, 3'b010, 5'(r)), 1'b0);
    idle(1, 1'b1, 1'b0);
    issue(fp(7'b1010000, 5'd2, 3'b010, 5'd23), 1'b0);
    issue(fp(7'b1010000, 5'd2, 3'b010, 5'd24), 1'b0);
    idle(1, 1'b1, 1'b0);
    check("t6_pre_count", fifo_count, 3);
    check("t6_pre_stall", stall_req, 1);
    rst = 1'b1;
    idle(1, 1'b1, 1'b1);
    rst = 1'b0;
    check("t6_valid", wb_valid, 0);
    check("t6_rd", wb_rd, 0);
    check("t6_data", wb_data, 0);
    check("t6_count", fifo_count, 0);
    check("t6_stall", stall_req, 0);
    check("t6_ovf", overflow_err, 0);
    idle(6, 1'b1, 1'b1);
    check("t6_no_capture", fifo_count, 0);
    check("t6_no_valid", wb_valid, 0);

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
